// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and limits for the two-master memory arbiter.
//               src_e tags the master that owns a transaction; arb_state_e
//               encodes the request-lock FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Upper bound on the outstanding-transaction FIFO depth.
    localparam int MEM_ARB_MAX_OUT_LIMIT = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_id_fifo
// Description : Small synchronous FIFO of source IDs. It records which master
//               owns each accepted transaction so that in-order responses can
//               be routed back to that master.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push/i_push_id - enqueue an ID (ignored when full)
//               i_pop            - dequeue the head (ignored when empty)
//               o_full/o_empty   - occupancy flags
//               o_head           - ID at the head of the queue
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  src_e i_push_id,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output src_e o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    src_e             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the head is only consumed while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : mem_arb_id_fifo
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one OBI-style memory port between the instruction
//               fetch and data interfaces. Data wins by default; instr wins
//               once data has beaten a waiting instr STARVE_LIMIT times. A
//               request left ungranted is locked until memory accepts it.
//               Accepted transactions are tracked in order so responses are
//               routed to their owner. No latency is added on either path.
// Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//               instr_*             - fetch master (req/addr/gnt/rvalid/rdata)
//               data_*              - load/store master
//               mem_*               - shared memory port
//               err_o               - sticky: response arrived with none pending
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    // Keep the FIFO depth inside the supported 1..MEM_ARB_MAX_OUT_LIMIT range.
    localparam int C_FIFO_DEPTH =
        (MAX_OUTSTANDING < 1) ? 1 :
        (MAX_OUTSTANDING > MEM_ARB_MAX_OUT_LIMIT) ? MEM_ARB_MAX_OUT_LIMIT :
        MAX_OUTSTANDING;
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    arb_state_e r_state;
    arb_state_e w_state_next;
    src_e       r_sel;
    src_e       w_sel;
    logic [3:0] r_starve_cnt;
    logic       r_err;

    logic w_data_wins;
    logic w_sel_req;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    src_e w_head;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Selection, next state and request-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_data_wins  = data_req_i &&
                       !(instr_req_i && (r_starve_cnt == C_STARVE_LIMIT));
        w_sel        = w_data_wins ? SRC_DATA : SRC_INSTR;
        w_sel_req    = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        instr_gnt_o  = 1'b0;
        data_gnt_o   = 1'b0;

        // A request already shown to memory must stay unchanged until granted.
        if (r_state == LOCK) begin
            w_sel = r_sel;
        end

        w_sel_req = (w_sel == SRC_DATA) ? data_req_i : instr_req_i;

        if (!rst_i) begin
            // No issue while the tracker is full, even if a response frees a
            // slot this cycle; that keeps the gate off the response path.
            mem_req_o = w_sel_req && !w_full;
            if (w_sel == SRC_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_we_o    = 1'b0;
                mem_be_o    = 4'hF;
                mem_wdata_o = '0;
            end
            instr_gnt_o = mem_req_o && mem_gnt_i && (w_sel == SRC_INSTR);
            data_gnt_o  = mem_req_o && mem_gnt_i && (w_sel == SRC_DATA);
        end

        case (r_state)
            ARB:     if (mem_req_o && !mem_gnt_i) w_state_next = LOCK;
            LOCK:    if (mem_req_o && mem_gnt_i)  w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    assign w_push = mem_req_o && mem_gnt_i;
    assign w_pop  = mem_rvalid_i && !w_empty && !rst_i;

    // ------------------------------------------------------------------
    // Locked source, starvation counter and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel        <= SRC_INSTR;
            r_starve_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            if (mem_req_o && !mem_gnt_i) begin
                r_sel <= w_sel;
            end
            if (w_push && (w_sel == SRC_INSTR)) begin
                r_starve_cnt <= '0;
            end else if (w_push && instr_req_i && (r_starve_cnt != C_STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (mem_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err && !rst_i;

    // ------------------------------------------------------------------
    // Outstanding-transaction tracker and response routing
    // ------------------------------------------------------------------
    mem_arb_id_fifo #(
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_push    (w_push),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    assign instr_rvalid_o = w_pop && (w_head == SRC_INSTR);
    assign data_rvalid_o  = w_pop && (w_head == SRC_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Inputs change
//               just after the falling edge; outputs are sampled 1 time unit
//               later, so each step observes the current registered state
//               combined with the new inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .err_o          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Wait for the falling edge at which the next step's inputs are applied.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_i;
        logic prev_i;

        // ---------------- reset: every output held at 0 ----------------
        rst = 1'b1; instr_req = 1'b1; instr_addr = 32'h0000_3000;
        data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_be = '0; data_wdata = '0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_mem_req",   mem_req, 0);
        chk("rst_instr_gnt", instr_gnt, 0);
        chk("rst_instr_rv",  instr_rvalid, 0);
        chk("rst_instr_rd",  instr_rdata, 0);
        step();
        step();

        // ---------------- T1: single fetch ----------------
        rst = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("t1_err_after_rst", err, 0);
        chk("t1_mem_req",   mem_req, 1);
        chk("t1_instr_gnt", instr_gnt, 1);
        chk("t1_mem_addr",  mem_addr, 32'h0000_3000);
        chk("t1_mem_be",    mem_be, 4'hF);
        chk("t1_mem_we",    mem_we, 0);
        step();
        instr_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        chk("t1_instr_rv", instr_rvalid, 1);
        chk("t1_instr_rd", instr_rdata, 32'h0000_0013);
        chk("t1_data_rv",  data_rvalid, 0);
        chk("t1_data_rd",  data_rdata, 0);
        step();
        mem_rvalid = 1'b0;

        // ---------------- T2: starvation pattern D,D,D,D,I ----------------
        instr_req = 1'b1; instr_addr = 32'h0000_0200;
        data_req = 1'b1; data_addr = 32'h0000_0100; data_we = 1'b1;
        data_be = 4'h3; data_wdata = 32'hDEAD_BEEF; mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            mem_rvalid = (i > 0);
            mem_rdata  = 32'h0000_1000 + 32'(i);
            #1;
            exp_i = ((i % 5) == 4);
            chk("t2_instr_gnt", instr_gnt, 32'(exp_i));
            chk("t2_data_gnt",  data_gnt, 32'(!exp_i));
            if (exp_i) begin
                chk("t2_starve_sat", 32'(dut.r_starve_cnt), 4);
                chk("t2_instr_be", mem_be, 4'hF);
                chk("t2_instr_addr", mem_addr, 32'h0000_0200);
            end else begin
                chk("t2_data_we", mem_we, 1);
                chk("t2_data_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            if (i == 5) chk("t2_starve_clr", 32'(dut.r_starve_cnt), 0);
            if (i > 0) begin
                prev_i = (((i - 1) % 5) == 4);
                chk("t2_instr_rv", instr_rvalid, 32'(prev_i));
                chk("t2_data_rv",  data_rvalid, 32'(!prev_i));
                chk("t2_rdata", prev_i ? instr_rdata : data_rdata, 32'h0000_1000 + 32'(i));
            end
        end
        step();
        instr_req = 1'b0; data_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_100A;
        #1;
        chk("t2_drain_rv", instr_rvalid, 1);
        chk("t2_drain_req", mem_req, 0);
        step();
        mem_rvalid = 1'b0;

        // ---------------- T3: lock on ungranted instr ----------------
        instr_req = 1'b1; instr_addr = 32'h0000_3000; mem_gnt = 1'b0;
        #1;
        chk("t3_c1_req", mem_req, 1);
        chk("t3_c1_gnt", instr_gnt, 0);
        step();
        data_req = 1'b1;
        #1;
        chk("t3_c2_lock", 32'(dut.r_state), 32'(LOCK));
        chk("t3_c2_addr", mem_addr, 32'h0000_3000);
        chk("t3_c2_dgnt", data_gnt, 0);
        chk("t3_c2_we",   mem_we, 0);
        step();
        #1;
        chk("t3_c3_addr", mem_addr, 32'h0000_3000);
        chk("t3_c3_lock", 32'(dut.r_state), 32'(LOCK));
        step();
        mem_gnt = 1'b1;
        #1;
        chk("t3_c4_igrant", instr_gnt, 1);
        chk("t3_c4_dgrant", data_gnt, 0);
        step();
        instr_req = 1'b0;
        #1;
        chk("t3_c5_dgrant", data_gnt, 1);
        chk("t3_c5_addr",   mem_addr, 32'h0000_0100);
        chk("t3_c5_state",  32'(dut.r_state), 32'(ARB));

        // ---------------- T4/T5: full gating and response routing ----------------
        step();
        data_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h0000_3004;
        #1;
        chk("t4_full_req", mem_req, 0);
        chk("t4_full_gnt", instr_gnt, 0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0000;
        #1;
        chk("t4_no_passthru", mem_req, 0);
        chk("t5_instr_rv", instr_rvalid, 1);
        chk("t5_instr_rd", instr_rdata, 32'hAAAA_0000);
        chk("t5_data_rv0", data_rvalid, 0);
        step();
        mem_rdata = 32'hBBBB_0000;
        #1;
        chk("t4_reassert", mem_req, 1);
        chk("t4_regrant",  instr_gnt, 1);
        chk("t5_data_rv",  data_rvalid, 1);
        chk("t5_data_rd",  data_rdata, 32'hBBBB_0000);
        chk("t5_instr_rd0", instr_rdata, 0);
        step();
        instr_req = 1'b0; mem_rdata = 32'h0000_0013;
        #1;
        chk("t5_last_rv", instr_rvalid, 1);
        step();
        mem_rdata = 32'h0000_DEAD;
        #1;
        chk("t5_stray_irv", instr_rvalid, 0);
        chk("t5_stray_drv", data_rvalid, 0);
        chk("t5_stray_drd", data_rdata, 0);
        chk("t5_err_pre",   err, 0);
        step();
        mem_rvalid = 1'b0;
        #1;
        chk("t5_err_set", err, 1);
        step();
        step();
        #1;
        chk("t5_err_sticky", err, 1);

        // ---------------- T6: reset with two outstanding ----------------
        instr_req = 1'b1; data_req = 1'b1; instr_addr = 32'h0000_4000;
        #1;
        chk("t6_dgrant", data_gnt, 1);
        step();
        data_req = 1'b0;
        #1;
        chk("t6_igrant", instr_gnt, 1);
        step();
        rst = 1'b1; data_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("t6_rst_req",  mem_req, 0);
        chk("t6_rst_ign",  instr_gnt, 0);
        chk("t6_rst_dgn",  data_gnt, 0);
        chk("t6_rst_irv",  instr_rvalid, 0);
        chk("t6_rst_drv",  data_rvalid, 0);
        chk("t6_rst_ird",  instr_rdata, 0);
        chk("t6_rst_drd",  data_rdata, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_be",   mem_be, 0);
        chk("t6_rst_err",  err, 0);
        step();
        #1;
        chk("t6_fifo_empty", 32'(dut.w_empty), 1);
        step();
        rst = 1'b0; data_req = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("t6_fresh_gnt",  instr_gnt, 1);
        chk("t6_fresh_addr", mem_addr, 32'h0000_4000);
        chk("t6_err_clear",  err, 0);
        step();
        instr_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        #1;
        chk("t6_fresh_rv", instr_rvalid, 1);
        chk("t6_fresh_rd", instr_rdata, 32'h0000_0077);
        step();
        mem_rvalid = 1'b0;
        #1;
        chk("t6_err_final", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares one OBI-style memory port between the core's instruction-fetch and data-access interfaces. It lets the core run against a single unified memory, both in simulation and in the formal harness. It sits between `core` and the memory model. It adds no request or response latency: it selects, locks and routes requests, and tracks outstanding transactions so that responses return to the correct master in order.

## Interface

Parameters:

- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions (1–4).
- `STARVE_LIMIT`, default 4: consecutive data wins while instr waits before instr gets priority (1–15).

Ports:

- `clk_i` input 1: clock.
- `rst_i` input 1: synchronous, active-high reset.
- `instr_req_i` input 1: fetch request.
- `instr_addr_i` input 32: fetch address.
- `instr_gnt_o` output 1: fetch accepted.
- `instr_rvalid_o` output 1: fetch response valid.
- `instr_rdata_o` output 32: fetch data.
- `data_req_i` input 1: load/store request.
- `data_addr_i` input 32: data address.
- `data_we_i` input 1: store.
- `data_be_i` input 4: byte enables.
- `data_wdata_i` input 32: store data.
- `data_gnt_o` output 1: data accepted.
- `data_rvalid_o` output 1: data response valid.
- `data_rdata_o` output 32: load data.
- `mem_req_o` output 1: memory request.
- `mem_addr_o` output 32: memory address.
- `mem_we_o` output 1: memory write.
- `mem_be_o` output 4: memory byte enables.
- `mem_wdata_o` output 32: memory write data.
- `mem_gnt_i` input 1: memory accepted the request.
- `mem_rvalid_i` input 1: memory response valid.
- `mem_rdata_i` input 32: memory response data.
- `err_o` output 1: sticky flag for an unexpected response.

## Operation

- Masters hold `req` and payload stable until they see `gnt` (OBI rule). The arbiter enforces the same rule toward memory.
- FSM states:
  - ARB: free selection.
  - LOCK: `mem_req_o` was driven without `mem_gnt_i`. The selected source is registered in `sel_q`, and that source stays selected until granted, even if a higher-priority request appears.
- ARB → LOCK when `mem_req_o && !mem_gnt_i`. LOCK → ARB on `mem_gnt_i`.
- Selection in ARB:
  - Data has priority by default.
  - Instr has priority when `starve_cnt_q == STARVE_LIMIT`.
- `starve_cnt_q` (4 bit):
  - Increments on each data grant while `instr_req_i` is high.
  - Clears on an instr grant.
  - Saturates at `STARVE_LIMIT`.
- Issue gating: `mem_req_o` is 0 while the outstanding FIFO is full. There is no same-cycle pass-through when a response frees a slot.
- On `mem_req_o && mem_gnt_i`, the source ID (0 = instr, 1 = data) is pushed to the FIFO.
- On `mem_rvalid_i` with a non-empty FIFO:
  - The head ID is popped.
  - `mem_rdata_i` and the rvalid are routed to that master only.
  - The other master's rdata is driven 0.
- Simultaneous push and pop is legal, and the FIFO count is unchanged.
- `mem_rvalid_i` with an empty FIFO: the response is dropped and `err_o` is set. `err_o` clears only on reset.
- `mem_we_o`, `mem_be_o` and `mem_wdata_o` come from data when data is selected. For instr selections they are 0 / 4'hF / 0.

## Timing

- Request path (`req` → `mem_req_o`, `mem_gnt_i` → `*_gnt_o`) is combinational: zero added cycles.
- Response path (`mem_rvalid_i` → `*_rvalid_o`) is combinational: zero added cycles.
- While `rst_i` is high, every output is 0. This includes the combinational `mem_req_o`, the `gnt` outputs and the `rvalid` outputs.
- At the first clock edge with `rst_i` high, the following are cleared:
  - FSM → ARB;
  - `sel_q` → instr;
  - `starve_cnt_q` → 0;
  - FIFO → empty;
  - `err_o` → 0.
- Reset in mid-transaction drops all in-flight IDs. Memory is reset together with the arbiter. A response that arrives after reset is released is flagged by `err_o`.
- A new grant is possible every cycle. Back-to-back grants to alternating masters are legal.

## Structure

- `mem_arb_pkg`:
  - `src_e` enum {SRC_INSTR, SRC_DATA};
  - `arb_state_e` enum {ARB, LOCK};
  - `MEM_ARB_MAX_OUT_LIMIT = 4`.
- Sub-module `mem_arb_id_fifo`: parameterized-depth FIFO of `src_e` with push, pop, full, empty and head. It is synchronous with registered storage.
- The top level holds the FSM, the starvation counter, the muxes and the error flag.

## Test plan

1. Instr only, addr 0x3000, `mem_gnt_i` = 1, rvalid 1 cycle later with 0x00000013:
   - `instr_gnt_o` = 1 in the same cycle;
   - `instr_rvalid_o` = 1 with rdata 0x00000013;
   - `data_rvalid_o` stays 0.
2. Both masters request continuously, `mem_gnt_i` = 1, STARVE_LIMIT = 4:
   - grant sequence D, D, D, D, I, repeating;
   - `starve_cnt_q` returns to 0 after each I grant.
3. Instr selected and `mem_gnt_i` = 0 for 3 cycles, with data raising req in cycle 2:
   - `mem_addr_o` stays at the instr addr;
   - FSM is in LOCK;
   - the instr grant lands in cycle 4, and the data grant follows in the next cycle.
4. MAX_OUTSTANDING = 2, two grants, no rvalid:
   - `mem_req_o` = 0 while full;
   - one rvalid pops the FIFO;
   - `mem_req_o` reasserts on the next cycle.
5. Interleaved I, D issue with rvalids returning 0xAAAA0000 then 0xBBBB0000:
   - instr receives 0xAAAA0000;
   - data receives 0xBBBB0000;
   - a third rvalid with the FIFO empty sets `err_o` = 1, which persists until `rst_i`.
6. `rst_i` pulsed with 2 transactions outstanding:
   - all outputs are 0 during reset;
   - FIFO is empty afterwards;
   - a fresh instr request is granted normally.
